// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer
//
// Trigger-driven capture sequencer for the 357 MHz ADC sample stream.
// When a trigger is accepted, the block first waits a programmable delay.
// It then opens a sample window with an incrementing RAM store address and
// fires a feedback-calculation strobe at a programmable index inside that
// window. At the end of the window it pulses capture_done and holds off for
// a programmable number of cycles before it can re-arm.
//
// Ports
//   clk357        sample clock, all logic on the rising edge
//   rst           asynchronous active-high reset
//   arm           level; a trigger is accepted only while arm is high
//   trig          synchronous trigger, sampled every cycle
//   trig_delay    cycles from trigger to first sample (D)
//   sample_len    window length in samples (L)
//   calc_offset   sample index at which calc_strb fires (C)
//   holdoff       dead cycles after capture_done (H)
//   clr_missed    clears trig_missed while idle
//   store_en      RAM write enable, high for each sample in the window
//   store_addr    RAM write address; holds its value outside the window
//   calc_strb     one-cycle feedback-calculation strobe
//   capture_done  one-cycle pulse in the cycle after the last sample
//   busy          high whenever the sequencer is not idle
//   trig_missed   sticky flag: a trigger arrived while busy
module adc_capture_sequencer #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DLY_W  = 12
) (
  input  logic              clk357,
  input  logic              rst,
  input  logic              arm,
  input  logic              trig,
  input  logic [DLY_W-1:0]  trig_delay,
  input  logic [ADDR_W-1:0] sample_len,
  input  logic [ADDR_W-1:0] calc_offset,
  input  logic [DLY_W-1:0]  holdoff,
  input  logic              clr_missed,
  output logic              store_en,
  output logic [ADDR_W-1:0] store_addr,
  output logic              calc_strb,
  output logic              capture_done,
  output logic              busy,
  output logic              trig_missed
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_SAMPLE,
    ST_HOLDOFF
  } state_t;

  state_t            state_q, state_d;
  // Shared down-counter: remaining delay cycles in DELAY, remaining dead
  // cycles in HOLDOFF (the capture_done cycle is the first HOLDOFF cycle).
  logic [DLY_W-1:0]  cnt_q, cnt_d;
  // Parameters latched at trigger acceptance and used for the whole capture.
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] coff_q, coff_d;
  logic [DLY_W-1:0]  hold_q, hold_d;

  logic              store_en_q, store_en_d;
  logic [ADDR_W-1:0] store_addr_q, store_addr_d;
  logic              calc_strb_q, calc_strb_d;
  logic              capture_done_q, capture_done_d;
  logic              busy_q, busy_d;
  logic              trig_missed_q, trig_missed_d;

  logic              start_window;

  // State and registered outputs.
  always_ff @(posedge clk357 or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      len_q          <= '0;
      coff_q         <= '0;
      hold_q         <= '0;
      store_en_q     <= 1'b0;
      store_addr_q   <= '0;
      calc_strb_q    <= 1'b0;
      capture_done_q <= 1'b0;
      busy_q         <= 1'b0;
      trig_missed_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      coff_q         <= coff_d;
      hold_q         <= hold_d;
      store_en_q     <= store_en_d;
      store_addr_q   <= store_addr_d;
      calc_strb_q    <= calc_strb_d;
      capture_done_q <= capture_done_d;
      busy_q         <= busy_d;
      trig_missed_q  <= trig_missed_d;
    end
  end

  // Next state and next-cycle outputs. Outputs are computed for the state
  // being entered, so every output is a flop.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    coff_d         = coff_q;
    hold_d         = hold_q;
    store_en_d     = 1'b0;
    store_addr_d   = store_addr_q;
    calc_strb_d    = 1'b0;
    capture_done_d = 1'b0;
    trig_missed_d  = trig_missed_q;
    start_window   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm && trig) begin
          len_d        = sample_len;
          coff_d       = calc_offset;
          hold_d       = holdoff;
          store_addr_d = '0;
          if (trig_delay != '0) begin
            state_d = ST_DELAY;
            cnt_d   = trig_delay;
          end else begin
            start_window = 1'b1;
          end
        end
      end

      ST_DELAY: begin
        if (cnt_q == DLY_W'(1)) begin
          start_window = 1'b1;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end

      ST_SAMPLE: begin
        if (store_addr_q == len_q - ADDR_W'(1)) begin
          state_d        = ST_HOLDOFF;
          capture_done_d = 1'b1;
          cnt_d          = hold_q;
        end else begin
          store_en_d   = 1'b1;
          store_addr_d = store_addr_q + ADDR_W'(1);
          // Addresses stay below L, so a match implies C < L.
          calc_strb_d  = ((store_addr_q + ADDR_W'(1)) == coff_q);
        end
      end

      ST_HOLDOFF: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Window entry, shared by zero-delay triggers and the end of DELAY.
    // len_d/coff_d/hold_d hold the values for this capture in both cases.
    if (start_window) begin
      if (len_d == '0) begin
        state_d        = ST_HOLDOFF;
        capture_done_d = 1'b1;
        cnt_d          = hold_d;
      end else begin
        state_d      = ST_SAMPLE;
        store_en_d   = 1'b1;
        store_addr_d = '0;
        calc_strb_d  = (coff_d == '0);
      end
    end

    // Missed-trigger flag: a set while busy wins over clr_missed.
    if (state_q != ST_IDLE) begin
      if (trig) begin
        trig_missed_d = 1'b1;
      end
    end else if (clr_missed) begin
      trig_missed_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign store_en     = store_en_q;
  assign store_addr   = store_addr_q;
  assign calc_strb    = calc_strb_q;
  assign capture_done = capture_done_q;
  assign busy         = busy_q;
  assign trig_missed  = trig_missed_q;

endmodule

// File: doc/adc_capture_sequencer.md
# adc_capture_sequencer

Trigger-driven sequencer that controls when the 357 MHz ADC sample stream is written into the per-channel capture RAMs. It also tells the feedback arithmetic when to start computing. On an accepted trigger it waits a programmable delay, opens a sample window of programmable length with an incrementing store address, and fires a calculation strobe at a programmable offset inside the window. It then enforces a hold-off before re-arming. It sits between the trigger input logic and the channel storage/feedback datapath in FONT5_base.

## Interface
- ADDR_W, 9: width of store address and sample length (max window 2^ADDR_W−1 samples)
- DLY_W, 12: width of trigger-delay and hold-off counters
- clk357  in  1  sample clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- arm  in  1  level; triggers accepted only while high
- trig  in  1  synchronous trigger, sampled every cycle (level or pulse)
- trig_delay  in  DLY_W  cycles from trigger to first sample (D)
- sample_len  in  ADDR_W  window length in samples (L)
- calc_offset  in  ADDR_W  sample index at which calc_strb fires (C)
- holdoff  in  DLY_W  dead cycles after capture_done (H)
- clr_missed  in  1  clears trig_missed
- store_en  out  1  RAM write enable, high for each sample in window
- store_addr  out  ADDR_W  RAM write address
- calc_strb  out  1  one-cycle feedback-calculation strobe
- capture_done  out  1  one-cycle pulse at end of window
- busy  out  1  high whenever state ≠ IDLE
- trig_missed  out  1  sticky: trigger seen while busy

## Operation
- States: IDLE, DELAY, SAMPLE, HOLDOFF.
- IDLE:
  - If arm & trig: latch D, L, C, H.
  - Go to DELAY; if D=0, go directly to SAMPLE; if D=0 and L=0, go directly to done handling.
- DELAY: count D cycles, then SAMPLE.
- SAMPLE:
  - store_en=1 with store_addr = 0,1,…,L−1, one per cycle.
  - calc_strb=1 in the cycle where store_addr=C, only if C<L. If C≥L, calc_strb never fires.
  - After the L-th sample, capture_done pulses for one cycle and the block enters HOLDOFF.
- HOLDOFF: count H cycles, then IDLE. If H=0, return to IDLE right after the capture_done cycle.
- Latched parameters are used for the whole capture. Input changes mid-capture take effect only at the next accepted trigger.
- arm deasserted mid-capture does not abort the capture. arm only gates acceptance.
- trig high in any non-IDLE state is ignored and sets trig_missed. The set takes priority over a simultaneous clr_missed.
- In IDLE, clr_missed clears trig_missed.
- trig high but arm low in IDLE: ignored; trig_missed is not set.
- All outputs are registered.
- Reset value of every output is 0; state resets to IDLE. Reset mid-capture drops the capture immediately with no capture_done.

## Timing
- Cycle 0 is the cycle in which an accepted trig is high.
- busy is high from cycle 1 through cycle D+L+1+H.
- store_en is high in cycles D+1 … D+L, with store_addr = n−(D+1) in cycle n.
- store_addr holds its last value when store_en=0. It is 0 after reset and returns to 0 at each accepted trigger.
- calc_strb is high in cycle D+1+C (C<L only).
- capture_done is high in cycle D+L+1. This holds for L=0, which gives cycle D+1 with no store_en.
- The first cycle the block can accept a new trigger is cycle D+L+2+H.
- store_addr never wraps: L ≤ 2^ADDR_W−1 by width, so the last address is L−1.
- Minimum trigger-to-trigger period is D+L+2+H cycles.

## Test plan
- D=3, L=4, C=2, H=2; trig pulse in cycle 0 with arm=1. Required:
  - store_en in cycles 4–7 with addr 0–3
  - calc_strb in cycle 6
  - capture_done in cycle 8
  - busy in cycles 1–10
  - second trig accepted in cycle 11
- D=0, L=1, C=0, H=0. Required: store_en and calc_strb both high in cycle 1 (addr 0), capture_done in cycle 2, idle in cycle 3.
- L=0 (D=5): required capture_done in cycle 6, no store_en, no calc_strb. Separately, C=7 with L=4: required no calc_strb.
- Missed trigger and clear. Required:
  - trig in cycle 5 during capture sets trig_missed with no restart.
  - clr_missed and trig in the same busy cycle leave trig_missed=1.
  - clr_missed in IDLE clears it.
- Gating and mid-capture changes. Required:
  - arm=0 with trig: no response.
  - arm dropped in cycle 2: capture still completes.
  - trig_delay changed mid-capture: old D honoured.
- rst asserted in cycle 5 of a D=3, L=8 capture. Required:
  - All outputs 0 asynchronously.
  - No capture_done.
  - A trig after reset release starts a fresh capture at addr 0.
